// File: rtl/sqrt_pipe_hs.sv
// rtl/sqrt_pipe_hs.sv - sequential restoring fixed-point square root with valid/ready handshake
//
// Purpose:
//   Computes root = floor(sqrt(rad * 2^FBITS)) and rem = rad * 2^FBITS - root^2
//   one root digit per clock. The operand is captured in IDLE, iterated in CALC
//   and the result is held in DONE until the consumer takes it.
//
// Parameters:
//   WIDTH  - radicand / root / remainder width (default 16)
//   FBITS  - fractional bits of radicand and root (default 8); WIDTH+FBITS even, FBITS < WIDTH
//   SIGNED - 1: rad is two's complement, negative operands return err=1 immediately
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   rad/rnd valid
//   in_ready   out  high only in IDLE
//   rad        in   [WIDTH-1:0] radicand
//   rnd        in   1 = round root to nearest (only with SQRT_ROUND_EN), 0 = truncate
//   out_valid  out  high only in DONE
//   out_ready  in   consumer accepts result
//   root       out  [WIDTH-1:0] square root, same fixed-point format as rad
//   rem        out  [WIDTH-1:0] truncation remainder
//   err        out  negative radicand (SIGNED=1 only)
//
// Configuration:
//   SQRT_ROUND_EN - when defined, one extra guard iteration is run and rnd=1
//                   rounds the root to nearest; rem stays the truncation remainder.

module sqrt_pipe_hs #(
    parameter int WIDTH  = 16,
    parameter int FBITS  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rad,
    input  logic             rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] root,
    output logic [WIDTH-1:0] rem,
    output logic             err
);

    localparam int N  = (WIDTH + FBITS) / 2;
    localparam int RW = 2 * N;
`ifdef SQRT_ROUND_EN
    localparam int ITERS = N + 1;
`else
    localparam int ITERS = N;
`endif
    localparam int QW = ITERS;
    // Partial remainder never exceeds 2*q, so N+3 bits cover the shifted
    // accumulator even on the guard iteration.
    localparam int AW = N + 3;
    localparam int CW = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]    cnt;
    logic [RW-1:0]    sr;
    logic [AW-1:0]    acc;
    logic [QW-1:0]    q;
    logic [WIDTH-1:0] root_r;
    logic [WIDTH-1:0] rem_r;
    logic             err_r;

    logic             neg;
    logic             last;
    logic [AW-1:0]    acc_sh;
    logic [AW:0]      sub_b;
    logic [AW:0]      trial;
    logic             ge;
    logic [AW-1:0]    acc_nxt;
    logic [QW-1:0]    q_nxt;

    assign neg  = (SIGNED != 0) && rad[WIDTH-1];
    assign last = (cnt == CW'(ITERS - 1));

    // One restoring step: bring down the next two radicand bits, try
    // subtracting {q,01}; keep the difference and shift in 1 if it did not
    // go negative, otherwise keep the shifted accumulator and shift in 0.
    always_comb begin
        acc_sh              = {acc[AW-3:0], sr[RW-1:RW-2]};
        sub_b               = '0;
        sub_b[QW+1:0]       = {q, 2'b01};
        trial               = {1'b0, acc_sh} - sub_b;
        ge                  = ~trial[AW];
        acc_nxt             = ge ? trial[AW-1:0] : acc_sh;
        q_nxt               = {q[QW-2:0], ge};
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (in_valid) state_n = neg ? S_DONE : S_CALC;
            S_CALC: if (last) state_n = S_DONE;
            S_DONE: if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

`ifdef SQRT_ROUND_EN
    logic          rnd_r;
    logic [AW-1:0] trem;
`else
    logic unused_rnd;
    assign unused_rnd = rnd;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sr     <= '0;
            acc    <= '0;
            q      <= '0;
            root_r <= '0;
            rem_r  <= '0;
            err_r  <= 1'b0;
`ifdef SQRT_ROUND_EN
            rnd_r  <= 1'b0;
            trem   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        acc <= '0;
                        q   <= '0;
                        sr  <= RW'(rad) << FBITS;
`ifdef SQRT_ROUND_EN
                        rnd_r <= rnd;
`endif
                        if (neg) begin
                            root_r <= '0;
                            rem_r  <= '0;
                            err_r  <= 1'b1;
                        end else begin
                            err_r  <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    sr  <= {sr[RW-3:0], 2'b00};
                    acc <= acc_nxt;
                    q   <= q_nxt;
`ifdef SQRT_ROUND_EN
                    // The remainder after the N-th step is the truncation
                    // remainder; the guard step only decides rounding.
                    if (cnt == CW'(N - 1)) trem <= acc_nxt;
                    if (last) begin
                        rem_r <= WIDTH'(trem);
                        if (rnd_r)
                            root_r <= WIDTH'(q_nxt[QW-1:1]) + WIDTH'(q_nxt[0]);
                        else
                            root_r <= WIDTH'(q_nxt[QW-1:1]);
                    end
`else
                    if (last) begin
                        root_r <= WIDTH'(q_nxt);
                        rem_r  <= WIDTH'(acc_nxt);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign root      = root_r;
    assign rem       = rem_r;
    assign err       = err_r;

endmodule

// File: tb/tb_sqrt_pipe_hs.sv
// tb/tb_sqrt_pipe_hs.sv - self-checking bench for sqrt_pipe_hs
module tb_sqrt_pipe_hs;

`ifdef SQRT_ROUND_EN
    localparam int ROUND = 1;
    localparam int LAT   = 13;
`else
    localparam int ROUND = 0;
    localparam int LAT   = 12;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, rnd, out_valid, out_ready, err;
    logic [15:0] rad, root, rem;
    logic        s_in_valid, s_in_ready, s_rnd, s_out_valid, s_out_ready, s_err;
    logic [15:0] s_rad, s_root, s_rem;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sqrt_pipe_hs #(.WIDTH(16), .FBITS(8), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rad(rad), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
        .root(root), .rem(rem), .err(err)
    );

    sqrt_pipe_hs #(.WIDTH(16), .FBITS(8), .SIGNED(1)) u_sdut (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .rad(s_rad), .rnd(s_rnd), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .root(s_root), .rem(s_rem), .err(s_err)
    );

    typedef struct {
        logic [15:0] rad;
        logic        rnd;
        logic [15:0] rt;
        logic [15:0] rr;
        logic [15:0] rem;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] r, input logic rn,
                          input logic [15:0] exp_root, input logic [15:0] exp_rem);
        int w;
        int c;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_before", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        rad      = r;
        rnd      = rn;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk($sformatf("latency_%h", r), c, LAT);
        chk($sformatf("root_%h_rnd%0d", r, rn), {16'd0, root}, {16'd0, exp_root});
        chk($sformatf("rem_%h", r), {16'd0, rem}, {16'd0, exp_rem});
        chk($sformatf("err_%h", r), {31'd0, err}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_take", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_s(input logic [15:0] r, input logic exp_err,
                         input logic [15:0] exp_root, input logic [15:0] exp_rem, input int exp_lat);
        int c;
        @(negedge clk);
        s_in_valid = 1'b1;
        s_rad      = r;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        c = 0;
        while (!s_out_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk($sformatf("s_latency_%h", r), c, exp_lat);
        chk($sformatf("s_err_%h", r), {31'd0, s_err}, {31'd0, exp_err});
        chk($sformatf("s_root_%h", r), {16'd0, s_root}, {16'd0, exp_root});
        chk($sformatf("s_rem_%h", r), {16'd0, s_rem}, {16'd0, exp_rem});
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        chk("s_out_valid_after_take", {31'd0, s_out_valid}, 32'd0);
    endtask

    initial begin
        logic [15:0] exp_r;
        logic        seen;
        int          c;

        //            rad       rnd   trunc     round     rem
        vecs[0] = '{16'h0400, 1'b0, 16'h0200, 16'h0200, 16'h0000};
        vecs[1] = '{16'h0003, 1'b0, 16'h001B, 16'h001C, 16'h0027};
        vecs[2] = '{16'h0003, 1'b1, 16'h001B, 16'h001C, 16'h0027};
        vecs[3] = '{16'hFFFF, 1'b1, 16'h0FFF, 16'h1000, 16'h1EFF};
        vecs[4] = '{16'hFFFF, 1'b0, 16'h0FFF, 16'h1000, 16'h1EFF};
        vecs[5] = '{16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0000};
        vecs[6] = '{16'h0002, 1'b1, 16'h0016, 16'h0017, 16'h001C};
        vecs[7] = '{16'h0001, 1'b1, 16'h0010, 16'h0010, 16'h0000};
        vecs[8] = '{16'h7FFF, 1'b1, 16'h0B50, 16'h0B50, 16'h0600};
        vecs[9] = '{16'h0200, 1'b1, 16'h016A, 16'h016A, 16'h001C};

        rst = 1'b1;
        in_valid = 1'b0; rad = '0; rnd = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_rad = '0; s_rnd = 1'b0; s_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_root", {16'd0, root}, 32'd0);
        chk("reset_rem", {16'd0, rem}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            exp_r = (ROUND != 0 && vecs[i].rnd) ? vecs[i].rr : vecs[i].rt;
            run_op(vecs[i].rad, vecs[i].rnd, exp_r, vecs[i].rem);
        end

        // Back-pressure: result held while out_ready=0, new operand ignored.
        @(negedge clk);
        in_valid = 1'b1; rad = 16'h0200; rnd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("hold_latency", c, LAT);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; rad = 16'h0100;
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_root", {16'd0, root}, 32'h016A);
            chk("hold_rem", {16'd0, rem}, 32'h001C);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_released", {31'd0, out_valid}, 32'd0);
        chk("idle_retains_root", {16'd0, root}, 32'h016A);
        chk("idle_retains_rem", {16'd0, rem}, 32'h001C);
        seen = 1'b0;
        repeat (LAT + 3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("ignored_operand_no_result", {31'd0, seen}, 32'd0);

        // Reset in the middle of CALC, after 6 iterations.
        @(negedge clk);
        in_valid = 1'b1; rad = 16'hFFFF; rnd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_root", {16'd0, root}, 32'd0);
        repeat (LAT + 2) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst_mid_no_pulse", {31'd0, seen}, 32'd0);
        run_op(16'h0100, 1'b0, 16'h0100, 16'h0000);

        // Signed instance: negative operands short-circuit to DONE.
        run_s(16'h8000, 1'b1, 16'h0000, 16'h0000, 0);
        run_s(16'h0400, 1'b0, 16'h0200, 16'h0000, LAT);
        run_s(16'hFFFF, 1'b1, 16'h0000, 16'h0000, 0);
        run_s(16'h0003, 1'b0, 16'h001B, 16'h0027, LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
